// File: rtl/bsg_cache_sbuf_queue_ctrl_pkg.sv
// Shared constants and types for the store-buffer queue controller.
// Holds the sbuf element count and the occupancy encoding.
// No logic; imported by the controller and its bench.
package bsg_cache_sbuf_queue_ctrl_pkg;

  // Number of entries in the store-buffer data queue (el0 tail, el1 head).
  localparam int SBUF_ELS = 2;

  // Occupancy of the queue; the fourth code of the 2-bit field is unreachable.
  typedef enum logic [1:0] {
    NUM_0 = 2'd0,
    NUM_1 = 2'd1,
    NUM_2 = 2'd2
  } sbuf_num_e;

endpackage

// File: rtl/bsg_cache_sbuf_queue_ctrl.sv
// Control sequencer for the 2-entry store-buffer queue (el0 tail, el1 head).
// Latency: an entry accepted into an empty queue is visible on v_o the next cycle.
// Backpressure: ready_o drops only when full and the head is not taken this cycle.
module bsg_cache_sbuf_queue_ctrl
  import bsg_cache_sbuf_queue_ctrl_pkg::*;
#(
  parameter bit safe_p = 1'b1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic v_i,
  output logic ready_o,
  output logic v_o,
  input  logic yumi_i,
  output logic el0_en_o,
  output logic el1_en_o,
  output logic mux0_sel_o,
  output logic mux1_sel_o,
  output logic el0_valid_o,
  output logic el1_valid_o,
  output logic empty_o,
  output logic full_o,
  output logic err_o
);

  sbuf_num_e r_num;
  sbuf_num_e w_num_next;
  logic      r_err;
  logic      w_err_next;
  logic      w_enq;
  logic      w_deq;

  // A full queue may still accept when the head leaves in the same cycle,
  // so ready_o has a deliberate combinational path from yumi_i.
  assign ready_o     = (r_num != NUM_2) | yumi_i;
  assign v_o         = (r_num != NUM_0);
  assign el1_valid_o = v_o;
  assign el0_valid_o = (r_num == NUM_2);
  assign mux1_sel_o  = v_o;
  assign empty_o     = (r_num == NUM_0);
  assign full_o      = (r_num == NUM_2);
  assign err_o       = r_err;

  // Reset discards everything, so no handshake is honoured while it is high.
  assign w_enq = v_i & ready_o & ~reset_i;
  assign w_deq = yumi_i & v_o & ~reset_i;

  // Underflow is a yumi with nothing at the head; it only latches the error.
  assign w_err_next = r_err | (safe_p & yumi_i & (r_num == NUM_0) & ~reset_i);

  // Next occupancy plus the element load enables and el1 source select.
  always_comb begin
    w_num_next = r_num;
    el0_en_o   = 1'b0;
    el1_en_o   = 1'b0;
    mux0_sel_o = 1'b0;
    case (r_num)
      NUM_0: begin
        if (w_enq) begin
          el1_en_o   = 1'b1;
          w_num_next = NUM_1;
        end
      end
      NUM_1: begin
        case ({w_enq, w_deq})
          2'b10: begin
            el0_en_o   = 1'b1;
            w_num_next = NUM_2;
          end
          2'b01: begin
            w_num_next = NUM_0;
          end
          2'b11: begin
            el1_en_o = 1'b1;
          end
          default: begin
          end
        endcase
      end
      NUM_2: begin
        // When full, an accepted enqueue always coincides with a dequeue.
        if (w_deq) begin
          el1_en_o   = 1'b1;
          mux0_sel_o = 1'b1;
          if (w_enq) begin
            el0_en_o = 1'b1;
          end else begin
            w_num_next = NUM_1;
          end
        end
      end
      default: begin
        w_num_next = NUM_0;
      end
    endcase
  end

  // Occupancy and sticky error registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_num <= NUM_0;
      r_err <= 1'b0;
    end else begin
      r_num <= w_num_next;
      r_err <= w_err_next;
    end
  end

  // Occupancy must never reach the unused fourth code.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (r_num inside {NUM_0, NUM_1, NUM_2})
        else $error("sbuf occupancy out of range");
    end
  end

  // Without the safe wrapper, a yumi while empty is a caller bug.
  if (!safe_p) begin : g_unsafe_chk
    // Flag a yumi presented with no valid head.
    always_ff @(posedge clk_i) begin
      if (!reset_i) begin
        assert (!(yumi_i && !v_o))
          else $error("sbuf yumi_i while empty");
      end
    end
  end

endmodule
